// File: rtl/dyno_pkg.sv
// Shared constants and FSM encoding for the dino game collision stage.
package dyno_pkg;

  localparam logic [10:0] DINO_L    = 11'd60;
  localparam logic [10:0] DINO_R    = 11'd100;
  localparam logic [10:0] CACTUS_W  = 11'd20;
  localparam logic [9:0]  CACTUS_H  = 10'd40;
  localparam logic [4:0]  HOLD_CYC  = 5'd16;
  localparam logic [13:0] SCORE_MAX = 14'd9999;

  localparam int unsigned NumCactus = 6;

  typedef enum logic [1:0] {
    StRun  = 2'd0,
    StHit  = 2'd1,
    StOver = 2'd2
  } state_e;

endpackage

// File: rtl/collision_ctrl_if.sv
// Bus between the scroll/dino stages (master) and the collision controller (slave).
interface collision_ctrl_if;

  logic [10:0] s1;
  logic [10:0] s2;
  logic [10:0] s3;
  logic [10:0] s4;
  logic [10:0] s5;
  logic [10:0] s6;
  logic [9:0]  dino_y;
  logic        restart;
  logic        freeze;
  logic        game_over;
  logic [13:0] score;
  logic [13:0] hi_score;
  logic [2:0]  hit_idx;

  modport master (
    output s1, s2, s3, s4, s5, s6, dino_y, restart,
    input  freeze, game_over, score, hi_score, hit_idx
  );

  modport slave (
    input  s1, s2, s3, s4, s5, s6, dino_y, restart,
    output freeze, game_over, score, hi_score, hit_idx
  );

endinterface

// File: rtl/hit_check.sv
// Combinational overlap test of one cactus against the dino hitbox.
module hit_check #(
  parameter logic [10:0] DINO_L   = dyno_pkg::DINO_L,
  parameter logic [10:0] DINO_R   = dyno_pkg::DINO_R,
  parameter logic [10:0] CACTUS_W = dyno_pkg::CACTUS_W,
  parameter logic [9:0]  CACTUS_H = dyno_pkg::CACTUS_H
) (
  input  logic [10:0] pos,
  input  logic [9:0]  dino_y,
  output logic        overlap
);

  logic [11:0] right_edge;

  // One extra bit so a cactus near the right margin cannot wrap into the hitbox.
  assign right_edge = {1'b0, pos} + {1'b0, CACTUS_W};

  assign overlap = (right_edge > {1'b0, DINO_L}) && (pos < DINO_R) && (dino_y < CACTUS_H);

endmodule

// File: rtl/collision_ctrl.sv
// Game state controller: detects dino/cactus collisions, runs RUN/HIT/OVER and keeps score.
module collision_ctrl #(
  parameter logic [10:0] DINO_L    = dyno_pkg::DINO_L,
  parameter logic [10:0] DINO_R    = dyno_pkg::DINO_R,
  parameter logic [10:0] CACTUS_W  = dyno_pkg::CACTUS_W,
  parameter logic [9:0]  CACTUS_H  = dyno_pkg::CACTUS_H,
  parameter logic [4:0]  HOLD_CYC  = dyno_pkg::HOLD_CYC,
  parameter logic [13:0] SCORE_MAX = dyno_pkg::SCORE_MAX
) (
  input logic             clk_16Hz,
  input logic             rst_n,
  collision_ctrl_if.slave bus
);

  import dyno_pkg::*;

  logic [10:0]          s_pos [NumCactus];
  logic [NumCactus-1:0] overlap;
  logic                 hit_any;
  logic [2:0]           first_idx;

  state_e      state_q;
  logic [4:0]  hold_q;
  logic        restart_q;
  logic        freeze_q;
  logic        over_q;
  logic [13:0] score_q;
  logic [13:0] hi_q;
  logic [2:0]  idx_q;

  assign s_pos[0] = bus.s1;
  assign s_pos[1] = bus.s2;
  assign s_pos[2] = bus.s3;
  assign s_pos[3] = bus.s4;
  assign s_pos[4] = bus.s5;
  assign s_pos[5] = bus.s6;

  for (genvar i = 0; i < NumCactus; i++) begin : g_hit
    hit_check #(
      .DINO_L   (DINO_L),
      .DINO_R   (DINO_R),
      .CACTUS_W (CACTUS_W),
      .CACTUS_H (CACTUS_H)
    ) u_hit_check (
      .pos     (s_pos[i]),
      .dino_y  (bus.dino_y),
      .overlap (overlap[i])
    );
  end

  // Scan downward so the lowest overlapping index is the one left standing.
  always_comb begin
    hit_any   = |overlap;
    first_idx = 3'd0;
    for (int i = NumCactus - 1; i >= 0; i--) begin
      if (overlap[i]) first_idx = 3'(i + 1);
    end
  end

  always_ff @(posedge clk_16Hz or negedge rst_n) begin
    if (!rst_n) begin
      state_q   <= StRun;
      hold_q    <= 5'd0;
      restart_q <= 1'b1;
      freeze_q  <= 1'b0;
      over_q    <= 1'b0;
      score_q   <= 14'd0;
      hi_q      <= 14'd0;
      idx_q     <= 3'd0;
    end else begin
      restart_q <= bus.restart;
      case (state_q)
        StRun: begin
          if (hit_any) begin
            state_q  <= StHit;
            freeze_q <= 1'b1;
            idx_q    <= first_idx;
            hold_q   <= 5'd0;
          end else if (score_q < SCORE_MAX) begin
            score_q <= score_q + 14'd1;
          end
        end
        StHit: begin
          if (hold_q == HOLD_CYC - 5'd1) begin
            state_q <= StOver;
            over_q  <= 1'b1;
            hold_q  <= 5'd0;
            if (score_q > hi_q) hi_q <= score_q;
          end else begin
            hold_q <= hold_q + 5'd1;
          end
        end
        StOver: begin
          // Only a fresh rising edge restarts; a level held since HIT does not.
          if (bus.restart && !restart_q) begin
            state_q  <= StRun;
            freeze_q <= 1'b0;
            over_q   <= 1'b0;
            score_q  <= 14'd0;
            idx_q    <= 3'd0;
          end
        end
        default: begin
          state_q  <= StRun;
          freeze_q <= 1'b0;
          over_q   <= 1'b0;
          hold_q   <= 5'd0;
        end
      endcase
    end
  end

  assign bus.freeze    = freeze_q;
  assign bus.game_over = over_q;
  assign bus.score     = score_q;
  assign bus.hi_score  = hi_q;
  assign bus.hit_idx   = idx_q;

endmodule

// File: tb/tb_collision_ctrl.sv
// Directed bench for collision_ctrl: hit detection, HIT/OVER timing, restart edge, hi-score, saturation.
module tb_collision_ctrl;

  logic        clk_16Hz = 1'b0;
  logic        rst_n;
  int unsigned n_checks = 0;
  int unsigned n_errors = 0;

  collision_ctrl_if bus ();

  collision_ctrl dut (
    .clk_16Hz (clk_16Hz),
    .rst_n    (rst_n),
    .bus      (bus)
  );

  always #5 clk_16Hz = ~clk_16Hz;

  task automatic check(input string tag, input int unsigned got, input int unsigned exp);
    n_checks++;
    if (got !== exp) begin
      n_errors++;
      $display("FAIL %s: got %0d, expected %0d", tag, got, exp);
    end
  endtask

  // Inputs change and outputs are sampled on the falling edge.
  task automatic step(input int n);
    repeat (n) @(negedge clk_16Hz);
  endtask

  task automatic park();
    bus.s1 = 11'd690;
    bus.s2 = 11'd710;
    bus.s3 = 11'd690;
    bus.s4 = 11'd710;
    bus.s5 = 11'd690;
    bus.s6 = 11'd710;
  endtask

  initial begin
    rst_n       = 1'b0;
    park();
    bus.dino_y  = 10'd0;
    bus.restart = 1'b0;
    step(1);
    check("rst_freeze", bus.freeze, 0);
    check("rst_over", bus.game_over, 0);
    check("rst_score", bus.score, 0);
    check("rst_hi", bus.hi_score, 0);
    check("rst_idx", bus.hit_idx, 0);
    rst_n = 1'b1;

    step(20);
    check("run20_score", bus.score, 20);
    check("run20_freeze", bus.freeze, 0);

    // Single hit on cactus 3
    bus.s3 = 11'd80;
    step(1);
    park();
    check("hit3_freeze", bus.freeze, 1);
    check("hit3_idx", bus.hit_idx, 3);
    check("hit3_score_hold", bus.score, 20);
    check("hit3_over0", bus.game_over, 0);
    step(15);
    check("hold15_over0", bus.game_over, 0);
    step(1);
    check("hold16_over1", bus.game_over, 1);
    check("over_hi20", bus.hi_score, 20);
    check("over_idx3", bus.hit_idx, 3);
    check("over_score20", bus.score, 20);

    bus.restart = 1'b1;
    step(1);
    bus.restart = 1'b0;
    check("rs1_over", bus.game_over, 0);
    check("rs1_freeze", bus.freeze, 0);
    check("rs1_score", bus.score, 0);
    check("rs1_idx", bus.hit_idx, 0);
    check("rs1_hi", bus.hi_score, 20);

    // Simultaneous overlaps: lowest index wins; lower score keeps old hi_score
    bus.s2 = 11'd70;
    bus.s5 = 11'd90;
    step(1);
    park();
    check("dual_idx", bus.hit_idx, 2);
    check("dual_freeze", bus.freeze, 1);
    step(16);
    check("dual_over", bus.game_over, 1);
    check("dual_hi_keep", bus.hi_score, 20);

    bus.restart = 1'b1;
    step(1);
    bus.restart = 1'b0;
    check("rs2_score", bus.score, 0);

    // Near misses: jumping dino, height boundary, sum boundary
    bus.s1     = 11'd80;
    bus.dino_y = 10'd50;
    step(5);
    check("jump_score", bus.score, 5);
    check("jump_freeze", bus.freeze, 0);
    bus.dino_y = 10'd40;
    step(1);
    check("y40_freeze", bus.freeze, 0);
    check("y40_score", bus.score, 6);
    bus.s1     = 11'd39;
    bus.dino_y = 10'd0;
    step(4);
    check("s39_freeze", bus.freeze, 0);
    check("s39_score", bus.score, 10);
    park();
    step(25);
    check("run35_score", bus.score, 35);

    // Restart held high from RUN through HIT into OVER must not restart
    bus.restart = 1'b1;
    bus.s4      = 11'd80;
    step(1);
    park();
    check("hit4_idx", bus.hit_idx, 4);
    check("hit4_score", bus.score, 35);
    step(16);
    check("hit4_over", bus.game_over, 1);
    check("hit4_hi35", bus.hi_score, 35);
    step(5);
    check("held_over", bus.game_over, 1);
    bus.restart = 1'b0;
    step(1);
    check("drop_over", bus.game_over, 1);
    bus.restart = 1'b1;
    step(1);
    bus.restart = 1'b0;
    check("rs3_over", bus.game_over, 0);
    check("rs3_score", bus.score, 0);
    check("rs3_hi", bus.hi_score, 35);

    // Asynchronous reset in the middle of HIT
    bus.s6 = 11'd80;
    step(1);
    park();
    step(3);
    check("hit6_idx", bus.hit_idx, 6);
    check("hit6_freeze", bus.freeze, 1);
    rst_n = 1'b0;
    #1;
    check("arst_freeze", bus.freeze, 0);
    check("arst_hi", bus.hi_score, 0);
    check("arst_idx", bus.hit_idx, 0);
    check("arst_score", bus.score, 0);
    step(1);
    rst_n = 1'b1;

    // Score saturation
    step(9998);
    check("sat_9998", bus.score, 9998);
    step(1);
    check("sat_9999", bus.score, 9999);
    step(3);
    check("sat_hold", bus.score, 9999);
    bus.s1 = 11'd80;
    step(1);
    park();
    check("sat_hit_idx", bus.hit_idx, 1);
    step(16);
    check("sat_over", bus.game_over, 1);
    check("sat_hi", bus.hi_score, 9999);

    $display("Simulation finished: %0d checks, %0d errors", n_checks, n_errors);
    $finish;
  end

endmodule

// File: doc/collision_ctrl.md
COLLISION_CTRL -- requirements
Module: collision_ctrl

Interface
REQ-001 Parameter DINO_L, 11'd60: left x edge of dino hitbox.
REQ-002 Parameter DINO_R, 11'd100: right x edge of dino hitbox (exclusive).
REQ-003 Parameter CACTUS_W, 11'd20: cactus width in pixels.
REQ-004 Parameter CACTUS_H, 10'd40: cactus height above ground.
REQ-005 Parameter HOLD_CYC, 5'd16: cycles spent in HIT before OVER.
REQ-006 Parameter SCORE_MAX, 14'd9999: score saturation value.
REQ-007 One clock; reset is asynchronous and active-low.
REQ-008 clk_16Hz  input  1  game tick clock.
REQ-009 rst_n  input  1  asynchronous active-low reset.
REQ-010 s1..s6  input  11 each  cactus x positions from the scroll stage; 0..710.
REQ-011 dino_y  input  10  dino height above ground, 0 = standing.
REQ-012 restart  input  1  level from debounced button.
REQ-013 freeze  output  1  halts the scroll stage and the dino stage.
REQ-014 game_over  output  1  high in OVER state.
REQ-015 score  output  14  binary score of the current run.
REQ-016 hi_score  output  14  best score since reset.
REQ-017 hit_idx  output  3  1..6 = cactus that caused the hit, 0 = none.

Function
REQ-018 Cactus i overlaps when (s_i + CACTUS_W > DINO_L) and (s_i < DINO_R) and (dino_y < CACTUS_H); the sum is computed 12 bits wide, with no wrap.
REQ-019 FSM states are RUN, HIT and OVER, with all transitions on the rising edge of clk_16Hz.
REQ-020 RUN: freeze=0 and game_over=0; score increments by 1 per cycle and saturates at SCORE_MAX.
REQ-021 RUN -> HIT on the first cycle any overlap is true; freeze is 1 starting the next cycle (latency 1); score does not increment on the transition cycle.
REQ-022 On simultaneous overlaps, hit_idx latches the lowest index; hit_idx holds until the next RUN entry, then clears to 0.
REQ-023 HIT: freeze=1; a hold counter runs from 0 to HOLD_CYC-1, then HIT -> OVER; restart is ignored in HIT.
REQ-024 On HIT -> OVER, hi_score <= score if score > hi_score, otherwise hi_score is unchanged.
REQ-025 OVER: freeze=1 and game_over=1; a restart rising edge (registered previous value 0, current value 1) -> RUN, with score and hit_idx cleared on the same edge.
REQ-026 A restart held high across OVER entry does not restart; a fresh 0->1 edge is required.
REQ-027 Restart edges in RUN or HIT are ignored.
REQ-028 Parked cactus positions (690, 710) never overlap with the default parameters; no special case is required.

Reset
REQ-029 rst_n=0 forces asynchronously: state=RUN, freeze=0, game_over=0, score=0, hi_score=0, hit_idx=0, hold counter=0, restart edge register=1.
REQ-030 Reset mid-HIT or mid-OVER discards the run and clears hi_score.

Structure
REQ-031 Package dyno_pkg holds DINO_L, DINO_R, CACTUS_W, CACTUS_H, SCORE_MAX, HOLD_CYC and the state encoding (RUN=2'd0, HIT=2'd1, OVER=2'd2).
REQ-032 Sub-module hit_check is a purely combinational single-cactus overlap test, instantiated 6 times; all state lives in collision_ctrl.
REQ-033 Encoding 2'd3 is unreachable and recovers to RUN.

Verification
REQ-034 Reset release, all s_i=690, dino_y=0, 20 cycles -> score=20, freeze=0.
REQ-035 s3=80, dino_y=0 for one cycle -> next cycle freeze=1, hit_idx=3; 16 cycles later game_over=1.
REQ-036 s2=70 and s5=90 in the same cycle, dino_y=0 -> hit_idx=2.
REQ-037 s1=80, dino_y=50 -> no hit, score keeps incrementing; s1=39 (sum 59 <= 60) -> no hit.
REQ-038 Game over with score=35, hi_score=0 -> hi_score=35; restart held high throughout -> stays in OVER; drop restart then raise it -> RUN, score=0, hi_score=35.
REQ-039 rst_n pulsed low in HIT -> immediately freeze=0, hi_score=0; force score near 9999 -> score holds at 9999.
